// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl: command-driven sequencer for the pipeline debug unit.
// It loads instruction memory, single-steps or runs the pipeline with halt
// detection, and streams register-file / data-memory dumps over valid/ready.
// Optional build macro DEBUG_CYCLE_CNT_EN: counts enabled pipeline cycles and
// appends that count as one extra word after every dump list.
module pipeline_debug_ctrl #(
  parameter int NB_REG     = 32,
  parameter int NB_CMD     = 3,
  parameter int IMEM_DEPTH = 256,
  parameter int N_REGS     = 32,
  parameter int NB_CNT     = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [NB_CMD-1:0] i_cmd,
  input  logic [NB_REG-1:0] i_cmd_arg,
  input  logic              i_halt,
  input  logic [NB_REG-1:0] i_dunit_reg,
  input  logic [NB_REG-1:0] i_dunit_mem_data,
  output logic              o_dunit_clk_en,
  output logic              o_dunit_reset_pc,
  output logic              o_dunit_w_mem,
  output logic [NB_REG-1:0] o_dunit_addr,
  output logic [NB_REG-1:0] o_dunit_data_if,
  output logic              o_tx_valid,
  output logic [NB_REG-1:0] o_tx_data,
  input  logic              i_tx_ready,
  output logic              o_load_ovf,
  output logic              o_err_cmd
);

  localparam logic [NB_CMD-1:0] CMD_CLR      = NB_CMD'(0);
  localparam logic [NB_CMD-1:0] CMD_LOAD     = NB_CMD'(1);
  localparam logic [NB_CMD-1:0] CMD_STEP     = NB_CMD'(2);
  localparam logic [NB_CMD-1:0] CMD_RUN      = NB_CMD'(3);
  localparam logic [NB_CMD-1:0] CMD_DUMP_REG = NB_CMD'(4);
  localparam logic [NB_CMD-1:0] CMD_DUMP_MEM = NB_CMD'(5);

  // Byte address of the last instruction word; the load pointer wraps after it.
  localparam logic [NB_REG-1:0] PTR_LAST = NB_REG'((IMEM_DEPTH - 1) * 4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_RUN,
    S_DUMP_RD,
`ifdef DEBUG_CYCLE_CNT_EN
    S_DUMP_TX,
    S_CNT_TX
`else
    S_DUMP_TX
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [NB_REG-1:0] ptr_q, ptr_d;          // instruction-memory byte pointer
  logic [NB_REG-1:0] arg_q, arg_d;          // latched LOAD instruction word
  logic [NB_REG-1:0] idx_q, idx_d;          // dump word index k
  logic [NB_REG-1:0] len_q, len_d;          // dump word count
  logic              dump_mem_q, dump_mem_d; // 1 = data memory, 0 = register file
  logic              rd_wait_q, rd_wait_d;   // second DUMP_RD cycle: read data valid
  logic [NB_REG-1:0] tx_data_q, tx_data_d;
  logic [NB_CNT-1:0] run_cnt_q, run_cnt_d;   // enabled cycles in current RUN
  logic [NB_CNT-1:0] run_lim_q, run_lim_d;   // RUN limit, 0 = until halt
  logic              clr_pulse_q, clr_pulse_d;
  logic              load_ovf_q, load_ovf_d;
  logic              err_cmd_q, err_cmd_d;
`ifdef DEBUG_CYCLE_CNT_EN
  logic [NB_CNT-1:0] cyc_cnt_q, cyc_cnt_d;   // saturating enabled-cycle count
`endif

  // Next-state logic: command decode, load pointer, run limit and dump sequencing.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    arg_d       = arg_q;
    idx_d       = idx_q;
    len_d       = len_q;
    dump_mem_d  = dump_mem_q;
    rd_wait_d   = rd_wait_q;
    tx_data_d   = tx_data_q;
    run_cnt_d   = run_cnt_q;
    run_lim_d   = run_lim_q;
    clr_pulse_d = 1'b0;
    load_ovf_d  = load_ovf_q;
    err_cmd_d   = err_cmd_q;
`ifdef DEBUG_CYCLE_CNT_EN
    cyc_cnt_d   = cyc_cnt_q;
    if ((state_q == S_STEP || state_q == S_RUN) && cyc_cnt_q != '1) begin
      cyc_cnt_d = cyc_cnt_q + NB_CNT'(1);
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          case (i_cmd)
            CMD_CLR: begin
              ptr_d       = '0;
              clr_pulse_d = 1'b1;
              load_ovf_d  = 1'b0;
              err_cmd_d   = 1'b0;
`ifdef DEBUG_CYCLE_CNT_EN
              cyc_cnt_d   = '0;
`endif
            end
            CMD_LOAD: begin
              arg_d   = i_cmd_arg;
              state_d = S_LOAD;
            end
            CMD_STEP: state_d = S_STEP;
            CMD_RUN: begin
              run_cnt_d = '0;
              run_lim_d = NB_CNT'(i_cmd_arg);
              // A pipeline already halted gets zero enabled cycles.
              if (!i_halt) state_d = S_RUN;
            end
            CMD_DUMP_REG: begin
              idx_d      = '0;
              len_d      = NB_REG'(N_REGS);
              dump_mem_d = 1'b0;
              rd_wait_d  = 1'b0;
              state_d    = S_DUMP_RD;
            end
            CMD_DUMP_MEM: begin
              idx_d      = '0;
              len_d      = i_cmd_arg;
              dump_mem_d = 1'b1;
              rd_wait_d  = 1'b0;
              if (i_cmd_arg != '0) state_d = S_DUMP_RD;
            end
            default: err_cmd_d = 1'b1;
          endcase
        end
      end
      S_LOAD: begin
        if (ptr_q == PTR_LAST) begin
          ptr_d      = '0;
          load_ovf_d = 1'b1;
        end else begin
          ptr_d = ptr_q + NB_REG'(4);
        end
        state_d = S_IDLE;
      end
      S_STEP: state_d = S_IDLE;
      S_RUN: begin
        run_cnt_d = run_cnt_q + NB_CNT'(1);
        if (i_halt || (run_lim_q != '0 && run_cnt_d == run_lim_q)) begin
          state_d = S_IDLE;
        end
      end
      S_DUMP_RD: begin
        // Address is held for two cycles so the synchronous read data has
        // settled before it is captured into the output register.
        if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          rd_wait_d = 1'b0;
          tx_data_d = dump_mem_q ? i_dunit_mem_data : i_dunit_reg;
          state_d   = S_DUMP_TX;
        end
      end
      S_DUMP_TX: begin
        if (i_tx_ready) begin
          if (idx_q == len_q - NB_REG'(1)) begin
`ifdef DEBUG_CYCLE_CNT_EN
            tx_data_d = NB_REG'(cyc_cnt_q);
            state_d   = S_CNT_TX;
`else
            state_d   = S_IDLE;
`endif
          end else begin
            idx_d   = idx_q + NB_REG'(1);
            state_d = S_DUMP_RD;
          end
        end
      end
`ifdef DEBUG_CYCLE_CNT_EN
      S_CNT_TX: begin
        if (i_tx_ready) state_d = S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      arg_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      dump_mem_q  <= 1'b0;
      rd_wait_q   <= 1'b0;
      tx_data_q   <= '0;
      run_cnt_q   <= '0;
      run_lim_q   <= '0;
      clr_pulse_q <= 1'b0;
      load_ovf_q  <= 1'b0;
      err_cmd_q   <= 1'b0;
`ifdef DEBUG_CYCLE_CNT_EN
      cyc_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      arg_q       <= arg_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      dump_mem_q  <= dump_mem_d;
      rd_wait_q   <= rd_wait_d;
      tx_data_q   <= tx_data_d;
      run_cnt_q   <= run_cnt_d;
      run_lim_q   <= run_lim_d;
      clr_pulse_q <= clr_pulse_d;
      load_ovf_q  <= load_ovf_d;
      err_cmd_q   <= err_cmd_d;
`ifdef DEBUG_CYCLE_CNT_EN
      cyc_cnt_q   <= cyc_cnt_d;
`endif
    end
  end

  // Output decode from the registered state; everything idles at zero.
  always_comb begin
    o_cmd_ready      = (state_q == S_IDLE);
    o_dunit_clk_en   = (state_q == S_STEP) || (state_q == S_RUN);
    o_dunit_w_mem    = (state_q == S_LOAD);
    o_dunit_reset_pc = (state_q == S_LOAD) || clr_pulse_q;
    o_dunit_data_if  = (state_q == S_LOAD) ? arg_q : '0;
    o_dunit_addr     = '0;
    if (state_q == S_LOAD) begin
      o_dunit_addr = ptr_q;
    end else if (state_q == S_DUMP_RD || state_q == S_DUMP_TX) begin
      o_dunit_addr = dump_mem_q ? {idx_q[NB_REG-3:0], 2'b00} : idx_q;
    end
`ifdef DEBUG_CYCLE_CNT_EN
    o_tx_valid = (state_q == S_DUMP_TX) || (state_q == S_CNT_TX);
`else
    o_tx_valid = (state_q == S_DUMP_TX);
`endif
    o_tx_data  = o_tx_valid ? tx_data_q : '0;
    o_load_ovf = load_ovf_q;
    o_err_cmd  = err_cmd_q;
  end

endmodule

// File: tb/tb_pipeline_debug_ctrl.sv
// Testbench for pipeline_debug_ctrl: randomized commands, a behavioural model
// that queues expected load writes, run lengths and dump words, and a monitor
// that pops and compares as the DUT presents them.
module tb_pipeline_debug_ctrl;

  localparam int NB_REG     = 32;
  localparam int NB_CMD     = 3;
  localparam int IMEM_DEPTH = 4;
  localparam int N_REGS     = 32;
  localparam int NB_CNT     = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [NB_CMD-1:0] i_cmd;
  logic [NB_REG-1:0] i_cmd_arg;
  logic              i_halt;
  logic [NB_REG-1:0] i_dunit_reg;
  logic [NB_REG-1:0] i_dunit_mem_data;
  logic              o_dunit_clk_en;
  logic              o_dunit_reset_pc;
  logic              o_dunit_w_mem;
  logic [NB_REG-1:0] o_dunit_addr;
  logic [NB_REG-1:0] o_dunit_data_if;
  logic              o_tx_valid;
  logic [NB_REG-1:0] o_tx_data;
  logic              i_tx_ready;
  logic              o_load_ovf;
  logic              o_err_cmd;

  always #5 clk = ~clk;

  pipeline_debug_ctrl #(
    .NB_REG(NB_REG), .NB_CMD(NB_CMD), .IMEM_DEPTH(IMEM_DEPTH),
    .N_REGS(N_REGS), .NB_CNT(NB_CNT)
  ) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd(i_cmd), .i_cmd_arg(i_cmd_arg), .i_halt(i_halt),
    .i_dunit_reg(i_dunit_reg), .i_dunit_mem_data(i_dunit_mem_data),
    .o_dunit_clk_en(o_dunit_clk_en), .o_dunit_reset_pc(o_dunit_reset_pc),
    .o_dunit_w_mem(o_dunit_w_mem), .o_dunit_addr(o_dunit_addr),
    .o_dunit_data_if(o_dunit_data_if), .o_tx_valid(o_tx_valid),
    .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
    .o_load_ovf(o_load_ovf), .o_err_cmd(o_err_cmd)
  );

  // Register file and data memory models with 1-cycle synchronous read.
  logic [31:0] reg_m  [N_REGS];
  logic [31:0] data_m [256];
  always @(posedge clk) begin
    i_dunit_reg      <= reg_m[o_dunit_addr[4:0]];
    i_dunit_mem_data <= data_m[o_dunit_addr[9:2]];
  end

  typedef struct { logic [31:0] addr; logic [31:0] data; } load_t;
  load_t       load_q [$];
  int          run_q  [$];
  logic [31:0] tx_q   [$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int      n_loads   = 0;
  longint  cyc_model = 0;
  int      halt_at   = 0;
  bit      halt_force = 0;
  int      rdy_mode  = 0;
  int      en_total  = 0;
  int      tx_count  = 0;
  int      tx_valid_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event not expected by the model", name);
  endtask

  // Model pushes.
  task automatic push_load(input logic [31:0] w);
    load_t e;
    e.addr = 32'((n_loads % IMEM_DEPTH) * 4);
    e.data = w;
    load_q.push_back(e);
    n_loads++;
  endtask

  task automatic push_run(input int n);
    if (n > 0) run_q.push_back(n);
    cyc_model += n;
  endtask

  task automatic push_dump_tail();
`ifdef DEBUG_CYCLE_CNT_EN
    tx_q.push_back(32'(cyc_model));
`endif
  endtask

  // Command driver: waits for ready, holds valid for the accepting edge.
  task automatic send_cmd(input logic [2:0] c, input logic [31:0] a);
    int t = 0;
    @(negedge clk);
    while (!o_cmd_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail_evt("cmd_ready_timeout");
    i_cmd_valid = 1'b1;
    i_cmd       = c;
    i_cmd_arg   = a;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    $display("cmd %0d arg %h issued", c, a);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!o_cmd_ready && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) fail_evt("idle_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clr();
    send_cmd(3'd0, 32'h0);
    n_loads   = 0;
    cyc_model = 0;
    wait_idle();
  endtask

  task automatic do_load(input logic [31:0] w);
    push_load(w);
    send_cmd(3'd1, w);
  endtask

  task automatic do_run(input int arg, input int h);
    int exp_n;
    halt_at = h;
    if (h == 0)      exp_n = arg;
    else if (arg == 0) exp_n = h;
    else             exp_n = (h < arg) ? h : arg;
    push_run(exp_n);
    send_cmd(3'd3, 32'(arg));
    wait_idle();
    halt_at = 0;
  endtask

  task automatic do_dump_reg();
    for (int k = 0; k < N_REGS; k++) tx_q.push_back(reg_m[k]);
    push_dump_tail();
    send_cmd(3'd4, 32'h0);
    wait_idle();
  endtask

  task automatic do_dump_mem(input int n);
    for (int k = 0; k < n; k++) tx_q.push_back(data_m[k]);
    if (n > 0) push_dump_tail();
    send_cmd(3'd5, 32'(n));
    wait_idle();
  endtask

  task automatic model_reset();
    n_loads   = 0;
    cyc_model = 0;
    tx_q.delete();
  endtask

  // Halt source: asserts i_halt during the halt_at-th enabled cycle of a run.
  int run_seen = 0;
  always @(negedge clk) begin
    #1;
    if (halt_force) begin
      i_halt = 1'b1;
    end else if (rst_n && o_dunit_clk_en) begin
      run_seen++;
      i_halt = (halt_at != 0 && run_seen == halt_at);
    end else begin
      run_seen = 0;
      i_halt   = 1'b0;
    end
  end

  // Sink ready pattern: 0 always, 1 toggle, 2 random, other never.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       i_tx_ready = 1'b1;
      1:       i_tx_ready = ~i_tx_ready;
      2:       i_tx_ready = 1'($urandom_range(0, 1));
      default: i_tx_ready = 1'b0;
    endcase
  end

  // Monitor: pops expected load writes, run lengths and dump words.
  int          en_len = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      en_len     = 0;
      prev_stall = 0;
    end else begin
      if (o_dunit_w_mem) begin
        if (load_q.size() == 0) fail_evt("unexpected_load");
        else begin
          load_t e;
          e = load_q.pop_front();
          check("load_addr", o_dunit_addr, e.addr);
          check("load_data", o_dunit_data_if, e.data);
          check("load_reset_pc", 32'(o_dunit_reset_pc), 32'd1);
          $display("load addr %h data %h", o_dunit_addr, o_dunit_data_if);
        end
      end
      if (o_dunit_clk_en) begin
        en_len++;
        en_total++;
      end else if (en_len != 0) begin
        if (run_q.size() == 0) fail_evt("unexpected_clk_en");
        else begin
          int exp_n;
          exp_n = run_q.pop_front();
          check("run_cycles", 32'(en_len), 32'(exp_n));
          $display("run burst %0d enabled cycles (model %0d)", en_len, exp_n);
        end
        en_len = 0;
      end
      if (o_tx_valid) begin
        tx_valid_cycles++;
        if (o_dunit_clk_en) fail_evt("clk_en_during_dump");
      end
      if (prev_stall) begin
        check("tx_hold_valid", 32'(o_tx_valid), 32'd1);
        check("tx_hold_data", o_tx_data, prev_data);
      end
      if (o_tx_valid && i_tx_ready) begin
        tx_count++;
        if (tx_q.size() == 0) fail_evt("unexpected_tx");
        else begin
          logic [31:0] w;
          w = tx_q.pop_front();
          check("tx_data", o_tx_data, w);
          $display("tx word %h (model %h)", o_tx_data, w);
        end
      end
      prev_stall = o_tx_valid && !i_tx_ready;
      prev_data  = o_tx_data;
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int e0, tc0, tv0;
    rst_n       = 1'b0;
    i_cmd_valid = 1'b0;
    i_cmd       = '0;
    i_cmd_arg   = '0;
    i_halt      = 1'b0;
    i_tx_ready  = 1'b1;
    for (int k = 0; k < N_REGS; k++) reg_m[k] = 32'(k * 3);
    for (int k = 0; k < 256; k++) data_m[k] = $urandom;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_clk_en", 32'(o_dunit_clk_en), 32'd0);
    check("rst_reset_pc", 32'(o_dunit_reset_pc), 32'd0);
    check("rst_w_mem", 32'(o_dunit_w_mem), 32'd0);
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rst_flags", {30'd0, o_load_ovf, o_err_cmd}, 32'd0);
    rst_n = 1'b1;

    // Loads: two directed words, then random words past the wrap point.
    do_clr();
    do_load(32'h0800_0010);
    do_load(32'h2006_000B);
    for (int i = 0; i < 3; i++) do_load($urandom);
    wait_idle();
    check("load_ovf_set", 32'(o_load_ovf), 32'(n_loads >= IMEM_DEPTH));
    do_clr();
    check("load_ovf_clr", 32'(o_load_ovf), 32'd0);
    do_load($urandom);
    wait_idle();

    // Steps and bounded/halted runs.
    for (int i = 0; i < 3; i++) begin
      push_run(1);
      send_cmd(3'd2, 32'h0);
      wait_idle();
    end
    do_run(10, 0);

    // Halt on the 7th enabled cycle: clk_en drops and ready returns together.
    halt_at = 7;
    push_run(7);
    send_cmd(3'd3, 32'h0);
    t = 0;
    while (!o_dunit_clk_en && t < 100) begin @(negedge clk); t++; end
    while (o_dunit_clk_en && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_evt("halt_run_timeout");
    #2;
    check("halt_ready", 32'(o_cmd_ready), 32'd1);
    wait_idle();
    halt_at = 0;

    for (int i = 0; i < 6; i++) do_run($urandom_range(1, 15), $urandom_range(0, 20));

    // Pipeline already halted at accept: zero enabled cycles.
    halt_force = 1'b1;
    e0 = en_total;
    send_cmd(3'd3, 32'd5);
    repeat (6) @(negedge clk);
    check("halted_run_cycles", 32'(en_total - e0), 32'd0);
    halt_force = 1'b0;
    wait_idle();

    // Register dump with toggling ready, then randomized contents.
    rdy_mode = 1;
    do_dump_reg();
    for (int k = 0; k < N_REGS; k++) reg_m[k] = $urandom;
    rdy_mode = 2;
    do_dump_reg();
    do_dump_mem($urandom_range(1, 12));
    rdy_mode = 0;
    do_dump_mem($urandom_range(1, 12));

    // Empty memory dump produces no output words.
    tc0 = tx_count;
    tv0 = tx_valid_cycles;
    send_cmd(3'd5, 32'h0);
    repeat (8) @(negedge clk);
    check("dump0_words", 32'(tx_count - tc0), 32'd0);
    check("dump0_valid", 32'(tx_valid_cycles - tv0), 32'd0);
    check("dump0_ready", 32'(o_cmd_ready), 32'd1);

    // Illegal opcodes.
    check("err_before", 32'(o_err_cmd), 32'd0);
    send_cmd(3'd7, 32'h0);
    wait_idle();
    check("err_cmd7", 32'(o_err_cmd), 32'd1);
    send_cmd(3'd6, 32'h0);
    wait_idle();
    check("err_cmd6", 32'(o_err_cmd), 32'd1);
    do_clr();
    check("err_clr", 32'(o_err_cmd), 32'd0);

    // Reset mid-RUN aborts at once.
    halt_at = 0;
    send_cmd(3'd3, 32'h0);
    repeat (3) @(negedge clk);
    check("abort_run_active", 32'(o_dunit_clk_en), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("abort_run_clk_en", 32'(o_dunit_clk_en), 32'd0);
    check("abort_run_tx", 32'(o_tx_valid), 32'd0);
    check("abort_run_ready", 32'(o_cmd_ready), 32'd1);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset during a stalled dump drops the pending word.
    rdy_mode = 3;
    send_cmd(3'd4, 32'h0);
    t = 0;
    while (!o_tx_valid && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) fail_evt("dump_valid_timeout");
    #3 rst_n = 1'b0;
    #1;
    check("abort_dump_tx", 32'(o_tx_valid), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_mode = 0;

    // Recovery: pointer restarts at 0 after reset.
    do_load($urandom);
    do_dump_mem(3);
    repeat (4) @(negedge clk);

    check("load_q_drained", 32'(load_q.size()), 32'd0);
    check("run_q_drained", 32'(run_q.size()), 32'd0);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
